// File: rtl/core_pkg.sv
// Constants shared by the pipeline blocks: default widths and the
// derived register-address width.
package core_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  function automatic int addr_width(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Register file bus: read ports, writeback, issue marking and scoreboard status.
interface regfile_sb_if #(
  parameter int XLEN = core_pkg::XLEN_DEF,
  parameter int NREG = core_pkg::NREG_DEF,
  parameter int NRD  = 2
);
  import core_pkg::*;

  localparam int AW = addr_width(NREG);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                we;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic                iss_valid;
  logic [AW-1:0]       iss_addr;
  logic                iss_ready;
  logic                flush;
  logic [AW:0]         pend_cnt;

  modport master (
    output rd_addr, we, wa, wd, iss_valid, iss_addr, flush,
    input  rd_data, rd_busy, iss_ready, pend_cnt
  );

  modport slave (
    input  rd_addr, we, wa, wd, iss_valid, iss_addr, flush,
    output rd_data, rd_busy, iss_ready, pend_cnt
  );

endinterface

// File: rtl/regfile_sb_rdport.sv
// One read port: zero-register, write bypass and array/pending selection.
module regfile_sb_rdport #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [AW-1:0]   addr,
  input  logic            wr_eff,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic [XLEN-1:0] arr_data,
  input  logic            arr_pend,
  output logic [XLEN-1:0] data,
  output logic            busy
);

  always_comb begin
    data = arr_data;
    busy = arr_pend;
    if (ZERO_REG != 0 && addr == '0) begin
      data = '0;
      busy = 1'b0;
    end else if (BYPASS != 0 && wr_eff && wa == addr) begin
      data = wd;
      busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with write bypass and a per-register pending-write scoreboard
// used by the hazard unit for RAW/WAW stalls.
module regfile_sb
  import core_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = NREG_DEF,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input logic        CLK,
  input logic        areset,
  regfile_sb_if.slave bus
);

  localparam int AW = addr_width(NREG);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pend;
  logic [AW:0]     cnt;

  logic wr_eff, iss_zero, iss_ok, iss_set, set_ev, clr_ev;

  assign wr_eff   = bus.we && (bus.wa != '0 || ZERO_REG == 0);
  assign iss_zero = (ZERO_REG != 0) && (bus.iss_addr == '0);
  // A write retiring the same register this cycle frees it for a new producer
  assign iss_ok   = iss_zero || !pend[bus.iss_addr] || (wr_eff && bus.wa == bus.iss_addr);
  assign iss_set  = bus.iss_valid && iss_ok && !iss_zero;

  assign set_ev = iss_set && !pend[bus.iss_addr];
  assign clr_ev = wr_eff && pend[bus.wa] && !(iss_set && bus.iss_addr == bus.wa);

  assign bus.iss_ready = iss_ok;
  assign bus.pend_cnt  = cnt;

  always_ff @(posedge CLK or negedge areset) begin
    if (!areset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_eff) begin
      regs[bus.wa] <= bus.wd;
    end
  end

  // Issue set is placed after write clear so a same-address pair leaves the bit set
  always_ff @(posedge CLK or negedge areset) begin
    if (!areset) begin
      pend <= '0;
      cnt  <= '0;
    end else if (bus.flush) begin
      pend <= '0;
      cnt  <= '0;
    end else begin
      if (wr_eff)  pend[bus.wa]       <= 1'b0;
      if (iss_set) pend[bus.iss_addr] <= 1'b1;
      cnt <= cnt + (AW+1)'(set_ev) - (AW+1)'(clr_ev);
    end
  end

  logic [XLEN-1:0] port_data [NRD];
  logic [NRD-1:0]  port_busy;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = bus.rd_addr[k*AW +: AW];

    regfile_sb_rdport #(
      .XLEN(XLEN), .AW(AW), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) u_rdport (
      .addr    (ra),
      .wr_eff  (wr_eff),
      .wa      (bus.wa),
      .wd      (bus.wd),
      .arr_data(regs[ra]),
      .arr_pend(pend[ra]),
      .data    (port_data[k]),
      .busy    (port_busy[k])
    );
  end

  always_comb begin
    bus.rd_data = '0;
    for (int k = 0; k < NRD; k++) bus.rd_data[k*XLEN +: XLEN] = port_data[k];
  end

  assign bus.rd_busy = port_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench: stimulus queues expected outputs, a negedge monitor checks them.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(32), .NREG(32), .NRD(2)) bus_main ();
  regfile_sb_if #(.XLEN(32), .NREG(32), .NRD(1)) bus_nb ();
  regfile_sb_if #(.XLEN(64), .NREG(16), .NRD(3)) bus_wide ();

  regfile_sb #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(1), .ZERO_REG(1))
    u_main (.CLK(clk), .areset(rst_n), .bus(bus_main));
  regfile_sb #(.XLEN(32), .NREG(32), .NRD(1), .BYPASS(0), .ZERO_REG(1))
    u_nb (.CLK(clk), .areset(rst_n), .bus(bus_nb));
  regfile_sb #(.XLEN(64), .NREG(16), .NRD(3), .BYPASS(1), .ZERO_REG(1))
    u_wide (.CLK(clk), .areset(rst_n), .bus(bus_wide));

  localparam int S_D0 = 0, S_D1 = 1, S_B0 = 2, S_B1 = 3, S_RDY = 4, S_CNT = 5;
  localparam int S_NB_D0 = 10;
  localparam int S_W_D0 = 20, S_W_D1 = 21, S_W_D2 = 22, S_W_CNT = 23, S_W_RDY = 24;

  typedef struct {
    string       name;
    int          sig;
    logic [63:0] val;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   stim_done = 1'b0;

  function automatic logic [63:0] sample(input int s);
    case (s)
      S_D0:    return 64'(bus_main.rd_data[31:0]);
      S_D1:    return 64'(bus_main.rd_data[63:32]);
      S_B0:    return 64'(bus_main.rd_busy[0]);
      S_B1:    return 64'(bus_main.rd_busy[1]);
      S_RDY:   return 64'(bus_main.iss_ready);
      S_CNT:   return 64'(bus_main.pend_cnt);
      S_NB_D0: return 64'(bus_nb.rd_data[31:0]);
      S_W_D0:  return bus_wide.rd_data[63:0];
      S_W_D1:  return bus_wide.rd_data[127:64];
      S_W_D2:  return bus_wide.rd_data[191:128];
      S_W_CNT: return 64'(bus_wide.pend_cnt);
      S_W_RDY: return 64'(bus_wide.iss_ready);
      default: return 64'hx;
    endcase
  endfunction

  task automatic push(input string n, input int s, input logic [63:0] v);
    q.push_back('{name: n, sig: s, val: v});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic main_idle();
    bus_main.we = 1'b0;
    bus_main.iss_valid = 1'b0;
    bus_main.flush = 1'b0;
  endtask

  task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
    bus_main.rd_addr = {a1, a0};
  endtask

  task automatic issue(input logic [4:0] a);
    bus_main.iss_valid = 1'b1;
    bus_main.iss_addr = a;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus_main.we = 1'b1;
    bus_main.wa = a;
    bus_main.wd = d;
  endtask

  // Monitor: compare every queued expectation against the settled outputs
  initial begin
    exp_t e;
    logic [63:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        act = sample(e.sig);
        checks++;
        if (act !== e.val) begin
          failures++;
          $display("FAIL %s: got %0h expected %0h", e.name, act, e.val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: stimulus did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bus_main.rd_addr = '0; bus_main.wa = '0; bus_main.wd = '0; bus_main.iss_addr = '0;
    main_idle();
    bus_nb.rd_addr = '0; bus_nb.we = 1'b0; bus_nb.wa = '0; bus_nb.wd = '0;
    bus_nb.iss_valid = 1'b0; bus_nb.iss_addr = '0; bus_nb.flush = 1'b0;
    bus_wide.rd_addr = '0; bus_wide.we = 1'b0; bus_wide.wa = '0; bus_wide.wd = '0;
    bus_wide.iss_valid = 1'b0; bus_wide.iss_addr = '0; bus_wide.flush = 1'b0;

    // Held in reset: outputs quiescent, issue ignored
    cyc();
    rd2(5'd5, 5'd1); issue(5'd3);
    push("rst_data", S_D0, 64'h0);
    push("rst_busy", S_B0, 64'h0);
    push("rst_ready", S_RDY, 64'h1);
    push("rst_cnt", S_CNT, 64'h0);
    cyc();
    rst_n = 1'b1; main_idle();

    // Write x5 then mark it pending, then reset mid-run
    cyc(); wr(5'd5, 32'hDEADBEEF); rd2(5'd5, 5'd0);
    push("x5_bypass", S_D0, 64'hDEADBEEF);
    cyc(); main_idle(); issue(5'd5);
    push("x5_stored", S_D0, 64'hDEADBEEF);
    push("x5_iss_ready", S_RDY, 64'h1);
    cyc(); main_idle();
    push("x5_busy", S_B0, 64'h1);
    push("x5_cnt", S_CNT, 64'h1);
    cyc(); rst_n = 1'b0;
    push("midrst_data", S_D0, 64'h0);
    push("midrst_cnt", S_CNT, 64'h0);
    push("midrst_busy", S_B0, 64'h0);
    cyc(); rst_n = 1'b1; bus_main.iss_addr = 5'd5;
    push("postrst_ready", S_RDY, 64'h1);
    push("postrst_data", S_D0, 64'h0);

    // Bypass enabled vs disabled
    cyc(); wr(5'd7, 32'h12345678); rd2(5'd7, 5'd0);
    bus_nb.we = 1'b1; bus_nb.wa = 5'd7; bus_nb.wd = 32'h12345678; bus_nb.rd_addr = 5'd7;
    push("byp_data", S_D0, 64'h12345678);
    push("byp_busy", S_B0, 64'h0);
    push("nobyp_old", S_NB_D0, 64'h0);
    cyc(); main_idle(); bus_nb.we = 1'b0;
    push("byp_after", S_D0, 64'h12345678);
    push("nobyp_after", S_NB_D0, 64'h12345678);

    // Zero register
    cyc(); wr(5'd0, 32'hFFFFFFFF); issue(5'd0); rd2(5'd0, 5'd0);
    push("x0_bypass", S_D0, 64'h0);
    push("x0_ready", S_RDY, 64'h1);
    cyc(); main_idle();
    push("x0_data", S_D0, 64'h0);
    push("x0_busy", S_B0, 64'h0);
    push("x0_cnt", S_CNT, 64'h0);

    // RAW/WAW on x3
    cyc(); issue(5'd3);
    push("x3_iss_ready", S_RDY, 64'h1);
    cyc(); main_idle(); rd2(5'd3, 5'd3);
    push("x3_busy0", S_B0, 64'h1);
    push("x3_busy1", S_B1, 64'h1);
    push("x3_cnt", S_CNT, 64'h1);
    push("x3_waw_block", S_RDY, 64'h0);
    cyc(); wr(5'd3, 32'hA5);
    push("x3_wb_data", S_D0, 64'hA5);
    push("x3_wb_busy", S_B0, 64'h0);
    push("x3_wb_ready", S_RDY, 64'h1);
    cyc(); main_idle();
    push("x3_done_busy", S_B0, 64'h0);
    push("x3_done_data", S_D0, 64'hA5);
    push("x3_done_cnt", S_CNT, 64'h0);

    // Same-edge write and issue on pending x9
    cyc(); issue(5'd9);
    cyc(); issue(5'd9); wr(5'd9, 32'h99);
    push("x9_ready", S_RDY, 64'h1);
    push("x9_cnt_before", S_CNT, 64'h1);
    cyc(); main_idle(); rd2(5'd9, 5'd0);
    push("x9_data", S_D0, 64'h99);
    push("x9_busy", S_B0, 64'h1);
    push("x9_cnt", S_CNT, 64'h1);
    cyc(); wr(5'd9, 32'h100);
    cyc(); main_idle();
    push("x9_clr_cnt", S_CNT, 64'h0);
    push("x9_clr_data", S_D0, 64'h100);

    // Write and issue to different addresses
    cyc(); issue(5'd10);
    cyc(); issue(5'd11); wr(5'd10, 32'h10);
    push("x10x11_ready", S_RDY, 64'h1);
    cyc(); main_idle(); rd2(5'd10, 5'd11);
    push("x10_busy", S_B0, 64'h0);
    push("x11_busy", S_B1, 64'h1);
    push("x10x11_cnt", S_CNT, 64'h1);
    cyc(); wr(5'd11, 32'h11);
    cyc(); main_idle();
    push("x11_clr_cnt", S_CNT, 64'h0);

    // Flush beats a concurrent issue and write-clear; data still written
    cyc(); issue(5'd1);
    cyc(); issue(5'd2);
    cyc(); issue(5'd4);
    cyc(); main_idle();
    push("pre_flush_cnt", S_CNT, 64'h3);
    cyc(); bus_main.flush = 1'b1; issue(5'd6); wr(5'd4, 32'h44);
    cyc(); main_idle(); rd2(5'd6, 5'd4);
    push("flush_cnt", S_CNT, 64'h0);
    push("flush_busy6", S_B0, 64'h0);
    push("flush_busy4", S_B1, 64'h0);
    push("flush_data4", S_D1, 64'h44);
    cyc(); rd2(5'd1, 5'd2);
    push("flush_busy1", S_B0, 64'h0);
    push("flush_busy2", S_B1, 64'h0);

    // Wide configuration: 64-bit, 16 registers, 3 ports
    cyc(); bus_wide.we = 1'b1; bus_wide.wa = 4'd3; bus_wide.wd = 64'h0123456789ABCDEF;
    cyc(); bus_wide.wa = 4'd15; bus_wide.wd = 64'hFEDCBA9876543210;
    cyc(); bus_wide.wa = 4'd0; bus_wide.wd = 64'hFFFFFFFFFFFFFFFF;
    cyc(); bus_wide.we = 1'b0; bus_wide.rd_addr = {4'd0, 4'd15, 4'd3};
    bus_wide.iss_valid = 1'b1; bus_wide.iss_addr = 4'd15;
    push("wide_p0", S_W_D0, 64'h0123456789ABCDEF);
    push("wide_p1", S_W_D1, 64'hFEDCBA9876543210);
    push("wide_p2_x0", S_W_D2, 64'h0);
    push("wide_iss_ready", S_W_RDY, 64'h1);
    cyc(); bus_wide.iss_valid = 1'b0; bus_wide.rd_addr = {4'd15, 4'd3, 4'd3};
    push("wide_same_p0", S_W_D0, 64'h0123456789ABCDEF);
    push("wide_same_p1", S_W_D1, 64'h0123456789ABCDEF);
    push("wide_p2_x15", S_W_D2, 64'hFEDCBA9876543210);
    push("wide_cnt", S_W_CNT, 64'h1);
    push("wide_waw_block", S_W_RDY, 64'h0);

    cyc(); cyc(); cyc();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    stim_done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
